a23_cache_flush_seq: RTL and testbench



---
 rtl/a23_cache_pkg.sv | 27 ++
 rtl/a23_cache_flush_seq.sv | 101 ++++++++++
 tb/tb_a23_cache_flush_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/a23_cache_pkg.sv
// Shared a23 cache constants and the flush sequencer state encoding.
// Default geometry matches the cache instance; the tag valid bit sits above the tag field.
// Imported by the flush sequencer and by the cache itself.
package a23_cache_pkg;

  // Default cache geometry shared with the cache
  localparam int DEFAULT_SETS  = 256;
  localparam int DEFAULT_WAYS  = 4;

  // Tag RAM entry layout: tag field with the valid bit as MSB
  localparam int TAG_W         = 20;
  localparam int TAG_VALID_BIT = TAG_W;

  // Flush sequencer states
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2,
    ST_IDLE  = 2'd3
  } flush_state_t;

  // True while a set-by-set invalidate sweep is running
  function automatic logic is_sweep(input flush_state_t s);
    return (s == ST_INIT) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/a23_cache_flush_seq.sv
// Cache flush sequencer: sweeps every tag RAM set with an all-ways invalidate write.
// Latency: trigger at cycle N -> first write at N+1, done pulse one cycle after the last write.
// Backpressure: i_tag_ready low holds the current set; the core stays stalled until DONE ends.
module a23_cache_flush_seq
  import a23_cache_pkg::*;
#(
  parameter  int SETS  = DEFAULT_SETS,
  parameter  int WAYS  = DEFAULT_WAYS,
  parameter  int CNT_W = 16,
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush_req,
  input  logic             i_cache_enable,
  input  logic             i_tag_ready,
  output logic             o_tag_wr_en,
  output logic [SET_W-1:0] o_tag_wr_set,
  output logic [WAYS-1:0]  o_tag_wr_way_mask,
  output logic             o_flush_stall,
  output logic             o_flush_busy,
  output logic             o_flush_done,
  output logic [CNT_W-1:0] o_flush_count
);

  flush_state_t     state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             en_dly_q;   // i_cache_enable delayed one cycle, for rising-edge detect

  logic busy;
  logic accept;
  logic last_set;
  logic trigger;

  assign busy     = is_sweep(state_q);
  assign accept   = busy && i_tag_ready;
  assign last_set = (set_q == SET_W'(SETS - 1));
  // A flush strobe and an enable rising edge in the same cycle collapse into one trigger
  assign trigger  = i_flush_req || (i_cache_enable && !en_dly_q);

  // Next-state, set walk, sweep counting and output decode
  always_comb begin
    state_d           = state_q;
    set_d             = set_q;
    count_d           = count_q;
    o_tag_wr_en       = busy;
    o_tag_wr_set      = set_q;
    o_tag_wr_way_mask = busy ? {WAYS{1'b1}} : {WAYS{1'b0}};
    o_flush_busy      = busy;
    o_flush_stall     = busy || (state_q == ST_DONE);
    o_flush_done      = (state_q == ST_DONE);
    o_flush_count     = count_q;

    case (state_q)
      // Triggers here are absorbed: the core is stalled, so the running sweep covers them
      ST_INIT, ST_FLUSH: begin
        if (accept) begin
          set_d = set_q + 1'b1;
          if (last_set) begin
            state_d = ST_DONE;
            set_d   = '0;
            // Only CP15-requested sweeps are counted, never the post-reset one
            if ((state_q == ST_FLUSH) && (count_q != {CNT_W{1'b1}})) begin
              count_d = count_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = trigger ? ST_FLUSH : ST_IDLE;
      end
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_FLUSH;
          set_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        set_d   = '0;
      end
    endcase
  end

  // State registers; reset restarts the full invalidate sweep
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= ST_INIT;
      set_q    <= '0;
      count_q  <= '0;
      en_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      count_q  <= count_d;
      en_dly_q <= i_cache_enable;
    end
  end

endmodule

// File: tb/tb_a23_cache_flush_seq.sv
// Self-checking bench for a23_cache_flush_seq with the default 256-set, 4-way geometry.
// Each "slot" is the interval just after a rising edge: inputs are driven and state-decoded outputs checked there.
// Expected values come from hand-derived vector tables and a per-sweep set scoreboard.
module tb_a23_cache_flush_seq;

  localparam int SETS  = 256;
  localparam int WAYS  = 4;
  localparam int CNT_W = 16;
  localparam int SET_W = $clog2(SETS);

  logic             clk = 1'b0;
  logic             i_rstn;
  logic             i_flush_req;
  logic             i_cache_enable;
  logic             i_tag_ready;
  logic             o_tag_wr_en;
  logic [SET_W-1:0] o_tag_wr_set;
  logic [WAYS-1:0]  o_tag_wr_way_mask;
  logic             o_flush_stall;
  logic             o_flush_busy;
  logic             o_flush_done;
  logic [CNT_W-1:0] o_flush_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  a23_cache_flush_seq #(.SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .i_clk             (clk),
    .i_rstn            (i_rstn),
    .i_flush_req       (i_flush_req),
    .i_cache_enable    (i_cache_enable),
    .i_tag_ready       (i_tag_ready),
    .o_tag_wr_en       (o_tag_wr_en),
    .o_tag_wr_set      (o_tag_wr_set),
    .o_tag_wr_way_mask (o_tag_wr_way_mask),
    .o_flush_stall     (o_flush_stall),
    .o_flush_busy      (o_flush_busy),
    .o_flush_done      (o_flush_done),
    .o_flush_count     (o_flush_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic fr;
    logic en;
    logic rdy;
    logic e_wr;
    logic e_busy;
    logic e_stall;
    logic e_done;
    int   e_set;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (slot %0d)", nm, act, exp, cyc);
    end
  endtask

  // Run one sweep from the current slot, which must show the write of start_set.
  // Optional flush_req pulses: once while set pulse_set is on the bus, and in the DONE slot.
  task automatic sweep(input string nm, input int start_set, input bit toggle,
                       input int pulse_set, input bit pulse_done, input int exp_cnt);
    int nxt   = start_set;
    int t0    = cyc;
    int guard = 0;
    int acc   = 0;
    bit rdy   = 1'b1;
    bit pulsed = 1'b0;
    bit [SETS-1:0] seen = '0;
    while (nxt < SETS && guard < 4 * SETS) begin
      i_tag_ready = rdy;
      i_flush_req = 1'b0;
      if (!pulsed && nxt == pulse_set) begin
        i_flush_req = 1'b1;
        pulsed      = 1'b1;
      end
      chk({nm, " wr_en"}, o_tag_wr_en, 1);
      chk({nm, " set"}, o_tag_wr_set, nxt);
      chk({nm, " mask"}, o_tag_wr_way_mask, 4'hF);
      chk({nm, " stall"}, o_flush_stall, 1);
      if (rdy) begin
        seen[nxt] = 1'b1;
        acc++;
        nxt++;
      end
      tick();
      guard++;
      if (toggle) rdy = !rdy;
    end
    if (nxt < SETS) begin
      chk({nm, " timeout"}, nxt, SETS);
      return;
    end
    chk({nm, " accepts"}, acc, SETS - start_set);
    chk({nm, " unique"}, $countones(seen), SETS - start_set);
    i_tag_ready = 1'b1;
    i_flush_req = pulse_done;
    chk({nm, " done"}, o_flush_done, 1);
    chk({nm, " done_busy"}, o_flush_busy, 0);
    chk({nm, " done_wr"}, o_tag_wr_en, 0);
    chk({nm, " done_stall"}, o_flush_stall, 1);
    chk({nm, " count"}, o_flush_count, exp_cnt);
    if (!toggle && start_set == 0) chk({nm, " done_lat"}, cyc - t0, SETS);
    tick();
    i_flush_req = 1'b0;
    if (!pulse_done) begin
      chk({nm, " idle_stall"}, o_flush_stall, 0);
      chk({nm, " idle_done"}, o_flush_done, 0);
      chk({nm, " idle_busy"}, o_flush_busy, 0);
      chk({nm, " idle_mask"}, o_tag_wr_way_mask, 0);
      chk({nm, " idle_count"}, o_flush_count, exp_cnt);
    end
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      i_flush_req    = vt[i].fr;
      i_cache_enable = vt[i].en;
      i_tag_ready    = vt[i].rdy;
      chk($sformatf("vec%0d wr_en", i), o_tag_wr_en, vt[i].e_wr);
      chk($sformatf("vec%0d busy", i), o_flush_busy, vt[i].e_busy);
      chk($sformatf("vec%0d stall", i), o_flush_stall, vt[i].e_stall);
      chk($sformatf("vec%0d done", i), o_flush_done, vt[i].e_done);
      chk($sformatf("vec%0d set", i), o_tag_wr_set, vt[i].e_set);
      chk($sformatf("vec%0d mask", i), o_tag_wr_way_mask, vt[i].e_wr ? 4'hF : 4'h0);
      tick();
    end
  endtask

  initial begin
    int g;
    //          fr    en    rdy   wr    busy  stall done  set
    // Same-cycle strobe + enable rise, then ready stalls at set 0
    vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    // Enable held high, then falling edge: no sweep
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    i_rstn         = 1'b0;
    i_flush_req    = 1'b0;
    i_cache_enable = 1'b0;
    i_tag_ready    = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst wr_en", o_tag_wr_en, 1);
    chk("rst set", o_tag_wr_set, 0);
    chk("rst mask", o_tag_wr_way_mask, 4'hF);
    chk("rst stall", o_flush_stall, 1);
    chk("rst busy", o_flush_busy, 1);
    chk("rst done", o_flush_done, 0);
    chk("rst count", o_flush_count, 0);

    // Post-reset sweep, not counted
    i_rstn = 1'b1;
    sweep("init", 0, 1'b0, -1, 1'b0, 0);

    // Flush strobe from IDLE
    i_flush_req = 1'b1;
    chk("trig idle_wr", o_tag_wr_en, 0);
    tick();
    i_flush_req = 1'b0;
    sweep("flush", 0, 1'b0, -1, 1'b0, 1);

    // Ready toggling 1,0,1,0: every set written once, in order
    i_flush_req = 1'b1;
    tick();
    sweep("toggle", 0, 1'b1, -1, 1'b0, 2);

    // Strobe at set 100 absorbed; strobe in DONE chains a second sweep
    i_flush_req = 1'b1;
    tick();
    sweep("absorb", 0, 1'b0, 100, 1'b1, 3);
    sweep("chain", 0, 1'b0, -1, 1'b0, 4);

    // Same-cycle strobe and enable rise: exactly one sweep
    apply_vecs(0, 5);
    sweep("enrise", 2, 1'b0, -1, 1'b0, 5);
    apply_vecs(6, 10);

    // Reset in the middle of a sweep at set 50
    i_flush_req = 1'b1;
    tick();
    i_flush_req = 1'b0;
    g = 0;
    while (o_tag_wr_set != SET_W'(50) && g < 2 * SETS) begin
      tick();
      g++;
    end
    chk("midrst reach50", o_tag_wr_set, 50);
    i_rstn = 1'b0;
    tick();
    chk("midrst busy", o_flush_busy, 1);
    chk("midrst set", o_tag_wr_set, 0);
    chk("midrst count", o_flush_count, 0);
    chk("midrst stall", o_flush_stall, 1);
    chk("midrst done", o_flush_done, 0);
    i_rstn = 1'b1;
    sweep("rst_sweep", 0, 1'b0, -1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
